accum_sequencer: RTL and testbench

Controller that sequences a signed accumulator over a programmed number of partial sums and hands the finished sum downstream. Sits between the partial-product stream of the computation network and the layer output path. It owns the accumulator register, clears it per output, counts accepted operands, and holds the result until the consumer takes it.

---
 rtl/accum_seq_pkg.sv | 40 ++++
 rtl/accum_seq_accum_reg.sv | 31 +++
 rtl/accum_sequencer.sv | 147 ++++++++++++++
 tb/tb_accum_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_seq_pkg.sv
// Shared types for the accumulator sequencer: FSM state encoding and the
// saturating add used when ACCUM_SEQ_SAT_EN is defined.
package accum_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  typedef struct packed {
    logic               clip;
    logic signed [63:0] sum;
  } sat_res_t;

  // Operands are sign-extended to 64 bits; the result is clamped to a bw-bit signed range
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        bw);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (bw - 32'd1)) - 65'sd1;
    lo = -(65'sd1 <<< (bw - 32'd1));
    if (s > hi) begin
      r.clip = 1'b1;
      r.sum  = hi[63:0];
    end else if (s < lo) begin
      r.clip = 1'b1;
      r.sum  = lo[63:0];
    end else begin
      r.clip = 1'b0;
      r.sum  = s[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_seq_accum_reg.sv
// Signed accumulator register with synchronous clear (priority over enable)
// and asynchronous active-low reset.
module accum_reg
  import accum_seq_pkg::*;
#(
  parameter int BITWIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_en,
  input  logic signed [BITWIDTH-1:0] i_d,
  output logic signed [BITWIDTH-1:0] o_q
);

  logic signed [BITWIDTH-1:0] acc_r;

  // Accumulator storage: clear wins over a load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r <= {BITWIDTH{1'b0}};
    end else if (i_clear) begin
      acc_r <= {BITWIDTH{1'b0}};
    end else if (i_en) begin
      acc_r <= i_d;
    end
  end

  assign o_q = acc_r;

endmodule

// File: rtl/accum_sequencer.sv
// Sequences a signed accumulator over a programmed number of partial sums and
// holds the result until taken. Define ACCUM_SEQ_SAT_EN for a saturating add.
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 256,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_valid,
  input  logic signed [BITWIDTH-1:0] i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic signed [BITWIDTH-1:0] o_result,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic [LEN_W-1:0]           o_count,
  output logic                       o_sat
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_e                     state_r;
  logic [LEN_W-1:0]           len_r;
  logic [LEN_W-1:0]           count_r;
  logic                       ready_r;
  logic                       valid_r;
  logic                       busy_r;
  logic                       sat_r;

  logic [LEN_W-1:0]           len_clamp_s;
  logic [LEN_W-1:0]           count_next_s;
  logic                       start_s;
  logic                       beat_s;
  logic                       clip_s;
  logic signed [BITWIDTH-1:0] acc_q_s;
  logic signed [BITWIDTH-1:0] acc_d_s;

  // Handshake qualifiers and clamped length
  always_comb begin
    start_s      = (state_r == IDLE) && i_start;
    beat_s       = (state_r == ACCUM) && i_valid;
    count_next_s = count_r + LEN_W'(1'b1);
    if (i_len > MAX_LEN_C) begin
      len_clamp_s = MAX_LEN_C;
    end else begin
      len_clamp_s = i_len;
    end
  end

`ifdef ACCUM_SEQ_SAT_EN
  sat_res_t sat_res_s;

  // Saturating add of the incoming partial sum
  always_comb begin
    sat_res_s = sat_add(64'(acc_q_s), 64'(i_data), BITWIDTH);
    acc_d_s   = sat_res_s.sum[BITWIDTH-1:0];
    clip_s    = sat_res_s.clip;
  end
`else
  // Wrap-around add of the incoming partial sum
  always_comb begin
    acc_d_s = acc_q_s + i_data;
    clip_s  = 1'b0;
  end
`endif

  accum_reg #(
    .BITWIDTH (BITWIDTH)
  ) u_accum_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (start_s),
    .i_en    (beat_s),
    .i_d     (acc_d_s),
    .o_q     (acc_q_s)
  );

  // Control FSM; output flags are registered alongside the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      len_r   <= {LEN_W{1'b0}};
      count_r <= {LEN_W{1'b0}};
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            len_r   <= len_clamp_s;
            count_r <= {LEN_W{1'b0}};
            sat_r   <= 1'b0;
            busy_r  <= 1'b1;
            if (len_clamp_s == {LEN_W{1'b0}}) begin
              state_r <= OUTPUT;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
            end else begin
              state_r <= ACCUM;
              valid_r <= 1'b0;
              ready_r <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (i_valid) begin
            count_r <= count_next_s;
            sat_r   <= sat_r | clip_s;
            if (count_next_s == len_r) begin
              state_r <= OUTPUT;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (i_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_r;
  assign o_valid  = valid_r;
  assign o_busy   = busy_r;
  assign o_count  = count_r;
  assign o_sat    = sat_r;
  assign o_result = acc_q_s;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed self-checking bench for accum_sequencer (BITWIDTH=16, MAX_LEN=256).
module tb_accum_sequencer;

  localparam int BW    = 16;
  localparam int LEN_W = 9;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 in_valid;
  logic signed [BW-1:0] data;
  logic                 out_ready;
  logic                 out_valid;
  logic signed [BW-1:0] result;
  logic                 cons_ready;
  logic                 busy;
  logic [LEN_W-1:0]     count;
  logic                 sat;

  int n_tests;
  int n_fail;

  accum_sequencer #(
    .BITWIDTH (BW),
    .MAX_LEN  (256)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_len    (len),
    .i_valid  (in_valid),
    .i_data   (data),
    .o_ready  (out_ready),
    .o_valid  (out_valid),
    .o_result (result),
    .i_ready  (cons_ready),
    .o_busy   (busy),
    .o_count  (count),
    .o_sat    (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic vld,
                            input logic bsy, input logic [LEN_W-1:0] cnt);
    check({tag, "_ready"}, {31'd0, out_ready}, {31'd0, rdy});
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, vld});
    check({tag, "_busy"},  {31'd0, busy},      {31'd0, bsy});
    check({tag, "_count"}, {23'd0, count},     {23'd0, cnt});
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic v, input logic signed [BW-1:0] d);
    in_valid = v;
    data     = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = 9'd0;
    in_valid   = 1'b0;
    data       = 16'sd0;
    cons_ready = 1'b1;
    #12;
    check_outs("rst", 1'b0, 1'b0, 1'b0, 9'd0);
    check("rst_result", {16'd0, result}, 32'h0);
    check("rst_sat", {31'd0, sat}, 32'h0);
    rst_n = 1'b1;
    tick();

    // len=4, back-to-back beats 1..4
    do_start(9'd4);
    check_outs("t1_start", 1'b1, 1'b0, 1'b1, 9'd0);
    beat(1'b1, 16'sd1);
    beat(1'b1, 16'sd2);
    beat(1'b1, 16'sd3);
    check_outs("t1_b3", 1'b1, 1'b0, 1'b1, 9'd3);
    beat(1'b1, 16'sd4);
    check_outs("t1_done", 1'b0, 1'b1, 1'b1, 9'd4);
    check("t1_result", {16'd0, result}, 32'h000A);
    tick();
    check_outs("t1_idle", 1'b0, 1'b0, 1'b0, 9'd4);

    // len=3 with gaps in i_valid; 5 - 7 + 2 = 0
    cons_ready = 1'b0;
    do_start(9'd3);
    beat(1'b1, 16'sd5);
    check("t2_c1", {23'd0, count}, 32'd1);
    beat(1'b0, 16'sd99);
    check("t2_c1h", {23'd0, count}, 32'd1);
    beat(1'b1, -16'sd7);
    check("t2_c2", {23'd0, count}, 32'd2);
    beat(1'b0, 16'sd50);
    beat(1'b1, 16'sd2);
    check_outs("t2_done", 1'b0, 1'b1, 1'b1, 9'd3);
    check("t2_result", {16'd0, result}, 32'h0000);
    cons_ready = 1'b1;
    tick();
    check_outs("t2_idle", 1'b0, 1'b0, 1'b0, 9'd3);

    // len=0 goes straight to OUTPUT with a cleared result
    in_valid = 1'b1;
    data     = 16'sd11;
    do_start(9'd0);
    check_outs("t3_out", 1'b0, 1'b1, 1'b1, 9'd0);
    check("t3_result", {16'd0, result}, 32'h0000);
    in_valid = 1'b0;
    tick();
    check_outs("t3_idle", 1'b0, 1'b0, 1'b0, 9'd0);

    // Back-pressure with ignored start and data during the hold
    cons_ready = 1'b0;
    do_start(9'd2);
    beat(1'b1, 16'sd100);
    beat(1'b1, 16'sd200);
    for (int i = 0; i < 5; i++) begin
      start    = 1'b1;
      len      = 9'd5;
      in_valid = 1'b1;
      data     = 16'sd7;
      check("t4_hold_result", {16'd0, result}, 32'd300);
      check_outs("t4_hold", 1'b0, 1'b1, 1'b1, 9'd2);
      tick();
    end
    start      = 1'b0;
    in_valid   = 1'b0;
    cons_ready = 1'b1;
    check("t4_final", {16'd0, result}, 32'd300);
    tick();
    check_outs("t4_idle", 1'b0, 1'b0, 1'b0, 9'd2);

    // Positive overflow
    do_start(9'd2);
    check("t5_sat_clr", {31'd0, sat}, 32'h0);
    beat(1'b1, 16'sh7FFF);
    beat(1'b1, 16'sd1);
`ifdef ACCUM_SEQ_SAT_EN
    check("t5_result", {16'd0, result}, 32'h7FFF);
    check("t5_sat", {31'd0, sat}, 32'h1);
`else
    check("t5_result", {16'd0, result}, 32'h8000);
    check("t5_sat", {31'd0, sat}, 32'h0);
`endif
    tick();

    // Negative overflow
    do_start(9'd2);
    check("t6_sat_clr", {31'd0, sat}, 32'h0);
    beat(1'b1, 16'sh8000);
    beat(1'b1, -16'sd1);
`ifdef ACCUM_SEQ_SAT_EN
    check("t6_result", {16'd0, result}, 32'h8000);
    check("t6_sat", {31'd0, sat}, 32'h1);
`else
    check("t6_result", {16'd0, result}, 32'h7FFF);
    check("t6_sat", {31'd0, sat}, 32'h0);
`endif
    tick();

    // Length above MAX_LEN is clamped to 256
    do_start(9'd300);
    in_valid = 1'b1;
    data     = 16'sd1;
    for (int i = 0; i < 255; i++) tick();
    check_outs("t7_b255", 1'b1, 1'b0, 1'b1, 9'd255);
    tick();
    in_valid = 1'b0;
    check_outs("t7_done", 1'b0, 1'b1, 1'b1, 9'd256);
    check("t7_result", {16'd0, result}, 32'd256);
    tick();

    // Reset mid-accumulation discards the partial sum
    do_start(9'd4);
    beat(1'b1, 16'sd50);
    beat(1'b1, 16'sd60);
    rst_n = 1'b0;
    #2;
    check_outs("t8_rst", 1'b0, 1'b0, 1'b0, 9'd0);
    check("t8_rst_result", {16'd0, result}, 32'h0);
    check("t8_rst_sat", {31'd0, sat}, 32'h0);
    rst_n = 1'b1;
    tick();
    do_start(9'd1);
    beat(1'b1, 16'sd9);
    check_outs("t8_done", 1'b0, 1'b1, 1'b1, 9'd1);
    check("t8_result", {16'd0, result}, 32'd9);
    tick();
    check_outs("t8_idle", 1'b0, 1'b0, 1'b0, 9'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
